// File: rtl/gray_input_decoder_if.sv
// Bundles the Gray bus input, error clear and decoded outputs of gray_input_decoder.
// master = the side driving the pins and consuming the count; slave = the decoder itself.
interface gray_input_decoder_if #(
    parameter int BITS  = 8,
    parameter int POS_W = 16
);
    logic [BITS-1:0]  gray_in;
    logic             clr_err;
    logic [BITS-1:0]  bin_out;
    logic [POS_W-1:0] pos;
    logic             step_valid;
    logic             step_dir;
    logic             err;
    logic             err_sticky;
    logic             locked;

    modport master (
        output gray_in, clr_err,
        input  bin_out, pos, step_valid, step_dir, err, err_sticky, locked
    );

    modport slave (
        input  gray_in, clr_err,
        output bin_out, pos, step_valid, step_dir, err, err_sticky, locked
    );
endinterface

// File: rtl/gray_input_decoder.sv
// Synchronises and debounces a Gray-coded bus, converts it to binary and tracks
// +/-1 steps in a wrapping signed position count, flagging illegal jumps.
module gray_input_decoder #(
    parameter int BITS   = 8,
    parameter int POS_W  = 16,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_input_decoder_if.slave   bus
);
    localparam int CNT_W = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

    typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} state_t;

    function automatic logic [BITS-1:0] gray2bin(input logic [BITS-1:0] g);
        logic [BITS-1:0] b;
        b[BITS-1] = g[BITS-1];
        for (int i = BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t                  state_q, state_d;
    logic [BITS-1:0]         sync1_q, sync1_d;
    logic [BITS-1:0]         sync2_q, sync2_d;
    logic [BITS-1:0]         cand_q, cand_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BITS-1:0]         acc_bin_q, acc_bin_d;
    logic [BITS-1:0]         bin_out_q, bin_out_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    step_valid_q, step_valid_d;
    logic                    step_dir_q, step_dir_d;
    logic                    err_q, err_d;
    logic                    err_sticky_q, err_sticky_d;

    logic                    stable;
    logic [BITS-1:0]         new_bin;
    logic [BITS-1:0]         diff;

    always_comb begin
        state_d      = state_q;
        sync1_d      = bus.gray_in;
        sync2_d      = sync1_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        acc_bin_d    = acc_bin_q;
        bin_out_d    = bin_out_q;
        pos_d        = pos_q;
        step_valid_d = 1'b0;
        step_dir_d   = step_dir_q;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;

        // Any disagreement between sync2 and the candidate restarts the stability window.
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        stable  = (sync2_q == cand_q) && (cnt_q == CNT_MAX);
        new_bin = gray2bin(cand_q);
        diff    = new_bin - acc_bin_q;

        case (state_q)
            ACQUIRE: begin
                if (stable) begin
                    acc_bin_d = new_bin;
                    bin_out_d = new_bin;
                    state_d   = TRACK;
                end
            end
            TRACK: begin
                // Every accepted change becomes the new baseline, legal or not.
                if (stable && (new_bin != acc_bin_q)) begin
                    acc_bin_d = new_bin;
                    bin_out_d = new_bin;
                    if (diff == BITS'(1)) begin
                        step_valid_d = 1'b1;
                        step_dir_d   = 1'b1;
                        pos_d        = pos_q + POS_W'(1);
                    end else if (diff == {BITS{1'b1}}) begin
                        step_valid_d = 1'b1;
                        step_dir_d   = 1'b0;
                        pos_d        = pos_q - POS_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ACQUIRE;
        endcase

        if (err_d) begin
            err_sticky_d = 1'b1;
        end else if (bus.clr_err) begin
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACQUIRE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            cand_q       <= '0;
            cnt_q        <= '0;
            acc_bin_q    <= '0;
            bin_out_q    <= '0;
            pos_q        <= '0;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            acc_bin_q    <= acc_bin_d;
            bin_out_q    <= bin_out_d;
            pos_q        <= pos_d;
            step_valid_q <= step_valid_d;
            step_dir_q   <= step_dir_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.bin_out    = bin_out_q;
    assign bus.pos        = pos_q;
    assign bus.step_valid = step_valid_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.locked     = (state_q == TRACK);
endmodule

// File: tb/tb_gray_input_decoder.sv
// Directed bench for gray_input_decoder at default parameters (BITS=8, POS_W=16, STABLE=4).
module tb_gray_input_decoder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gray_input_decoder_if #(.BITS(8), .POS_W(16)) bus ();

    gray_input_decoder #(.BITS(8), .POS_W(16), .STABLE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] g);
        rst = 1'b1;
        bus.gray_in = g;
        bus.clr_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        int nstep, nerr;
        rst = 1'b1;
        bus.gray_in = 8'h00;
        bus.clr_err = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.bin_out, bus.pos, bus.step_valid, bus.step_dir, bus.err, bus.err_sticky, bus.locked} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got bin=%h pos=%h sv=%b dir=%b err=%b sticky=%b locked=%b, want all 0",
                     bus.bin_out, bus.pos, bus.step_valid, bus.step_dir, bus.err, bus.err_sticky, bus.locked);
        end
        rst = 1'b0;
        nstep = 0; nerr = 0;
        repeat (3) begin
            tick();
            nstep += int'(bus.step_valid); nerr += int'(bus.err);
        end
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_early_lock: locked=%b after 3 edges, want 0", bus.locked);
        end
        repeat (2) begin
            tick();
            nstep += int'(bus.step_valid); nerr += int'(bus.err);
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL reset_lock: locked=%b, want 1", bus.locked);
        end
        checks++;
        if (nstep != 0 || nerr != 0) begin
            errors++;
            $display("FAIL reset_no_pulse: steps=%0d errs=%0d, want 0 0", nstep, nerr);
        end
    endtask

    task automatic test_up_count();
        logic [7:0] seq [3] = '{8'h01, 8'h03, 8'h02};
        int nstep, nup, nerr;
        nstep = 0; nup = 0; nerr = 0;
        for (int k = 0; k < 3; k++) begin
            bus.gray_in = seq[k];
            repeat (10) begin
                tick();
                if (bus.step_valid) begin
                    nstep++;
                    if (bus.step_dir === 1'b1) nup++;
                end
                nerr += int'(bus.err);
            end
        end
        checks++;
        if (nstep != 3 || nup != 3) begin
            errors++;
            $display("FAIL up_steps: steps=%0d up=%0d, want 3 3", nstep, nup);
        end
        checks++;
        if (nerr != 0) begin
            errors++;
            $display("FAIL up_err: errs=%0d, want 0", nerr);
        end
        checks++;
        if (bus.pos !== 16'd3 || bus.bin_out !== 8'h03) begin
            errors++;
            $display("FAIL up_final: pos=%h bin=%h, want 0003 03", bus.pos, bus.bin_out);
        end
    endtask

    task automatic test_down_wrap();
        int nstep, ndown;
        do_reset(8'h00);
        nstep = 0; ndown = 0;
        bus.gray_in = 8'h80;
        repeat (12) begin
            tick();
            if (bus.step_valid) begin
                nstep++;
                if (bus.step_dir === 1'b0) ndown++;
            end
        end
        checks++;
        if (nstep != 1 || ndown != 1) begin
            errors++;
            $display("FAIL down_step: steps=%0d down=%0d, want 1 1", nstep, ndown);
        end
        checks++;
        if (bus.bin_out !== 8'hFF || bus.pos !== 16'hFFFF) begin
            errors++;
            $display("FAIL down_wrap: bin=%h pos=%h, want ff ffff", bus.bin_out, bus.pos);
        end
        bus.gray_in = 8'h00;
        repeat (12) tick();
        checks++;
        if (bus.bin_out !== 8'h00 || bus.pos !== 16'h0000 || bus.step_dir !== 1'b1 || bus.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap: bin=%h pos=%h dir=%b sticky=%b, want 00 0000 1 0",
                     bus.bin_out, bus.pos, bus.step_dir, bus.err_sticky);
        end
    endtask

    task automatic test_glitch();
        int nstep, nerr;
        do_reset(8'h00);
        nstep = 0; nerr = 0;
        bus.gray_in = 8'h01;
        repeat (3) begin
            tick();
            nstep += int'(bus.step_valid); nerr += int'(bus.err);
        end
        bus.gray_in = 8'h00;
        repeat (15) begin
            tick();
            nstep += int'(bus.step_valid); nerr += int'(bus.err);
        end
        checks++;
        if (nstep != 0 || nerr != 0 || bus.bin_out !== 8'h00 || bus.pos !== 16'd0) begin
            errors++;
            $display("FAIL glitch: steps=%0d errs=%0d bin=%h pos=%h, want 0 0 00 0000",
                     nstep, nerr, bus.bin_out, bus.pos);
        end
    endtask

    task automatic test_illegal_jump();
        do_reset(8'h00);
        bus.gray_in = 8'h03;
        repeat (6) tick();
        checks++;
        if (bus.err !== 1'b0 || bus.bin_out !== 8'h00) begin
            errors++;
            $display("FAIL jump_early: err=%b bin=%h at edge 5, want 0 00", bus.err, bus.bin_out);
        end
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.step_valid !== 1'b0 || bus.err_sticky !== 1'b1 ||
            bus.bin_out !== 8'h02 || bus.pos !== 16'd0) begin
            errors++;
            $display("FAIL jump_edge6: err=%b sv=%b sticky=%b bin=%h pos=%h, want 1 0 1 02 0000",
                     bus.err, bus.step_valid, bus.err_sticky, bus.bin_out, bus.pos);
        end
        tick();
        checks++;
        if (bus.err !== 1'b0 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL jump_pulse_width: err=%b sticky=%b, want 0 1", bus.err, bus.err_sticky);
        end
        bus.gray_in = 8'h02;
        repeat (10) tick();
        checks++;
        if (bus.pos !== 16'd1 || bus.bin_out !== 8'h03 || bus.step_dir !== 1'b1) begin
            errors++;
            $display("FAIL jump_resync: pos=%h bin=%h dir=%b, want 0001 03 1", bus.pos, bus.bin_out, bus.step_dir);
        end
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        checks++;
        if (bus.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: sticky=%b, want 0", bus.err_sticky);
        end
        // 3 -> 0 is an illegal jump; clr_err lands on the same edge as the err pulse
        bus.gray_in = 8'h00;
        repeat (6) tick();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_err: err=%b sticky=%b, want 1 1", bus.err, bus.err_sticky);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] seq [5] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
        int nstep, nerr;
        do_reset(8'h00);
        for (int k = 0; k < 5; k++) begin
            bus.gray_in = seq[k];
            repeat (10) tick();
        end
        checks++;
        if (bus.pos !== 16'd5 || bus.bin_out !== 8'h05) begin
            errors++;
            $display("FAIL mid_setup: pos=%h bin=%h, want 0005 05", bus.pos, bus.bin_out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.bin_out, bus.pos, bus.step_valid, bus.step_dir, bus.err, bus.err_sticky, bus.locked} !== 29'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: bin=%h pos=%h sv=%b dir=%b err=%b sticky=%b locked=%b, want all 0",
                     bus.bin_out, bus.pos, bus.step_valid, bus.step_dir, bus.err, bus.err_sticky, bus.locked);
        end
        nstep = 0; nerr = 0;
        repeat (20) begin
            tick();
            nstep += int'(bus.step_valid); nerr += int'(bus.err);
        end
        checks++;
        if (bus.locked !== 1'b1 || bus.bin_out !== 8'h05 || bus.pos !== 16'd0 || nstep != 0 || nerr != 0) begin
            errors++;
            $display("FAIL mid_relock: locked=%b bin=%h pos=%h steps=%0d errs=%0d, want 1 05 0000 0 0",
                     bus.locked, bus.bin_out, bus.pos, nstep, nerr);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        bus.gray_in = 8'h00;
        bus.clr_err = 1'b0;
        checks = 0;
        errors = 0;
        test_reset();
        test_up_count();
        test_down_wrap();
        test_glitch();
        test_illegal_jump();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_input_decoder.md
# gray_input_decoder

Receive-side counterpart to the LED Gray-code display driver. Samples an external BITS-wide Gray-coded bus, such as a looped-back LED header or an absolute encoder, and synchronises and debounces it. It then converts the value to binary, classifies each accepted change as one step up, one step down, or an illegal jump, and maintains a wrapping signed position count. It sits between the board I/O pins and any logic that needs the decoded count.

## Interface
- BITS, default 8: Gray bus width; must be ≥ 2.
- POS_W, default 16: position counter width; must be ≥ BITS.
- STABLE, default 4: consecutive identical synchronised samples required before a value is accepted; must be ≥ 1.

- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- gray_in  input  BITS  asynchronous Gray-coded bus.
- clr_err  input  1  synchronous clear of err_sticky.
- bin_out  output  BITS  binary value of the last accepted code; registered.
- pos  output  POS_W  accumulated position; wraps modulo 2^POS_W.
- step_valid  output  1  one-cycle pulse on each accepted ±1 step.
- step_dir  output  1  direction of the last step: 1 = up, 0 = down; holds between pulses.
- err  output  1  one-cycle pulse when an accepted change is not ±1.
- err_sticky  output  1  set by err; cleared by clr_err or rst.
- locked  output  1  high in TRACK state.

## Operation
- Reset values: all outputs 0. sync1, sync2, cand, cnt and acc_bin are 0. The state machine starts in ACQUIRE.
- Synchroniser: two flops, gray_in → sync1 → sync2.
- Debounce:
  - If sync2 ≠ cand: cand ← sync2, cnt ← 0.
  - Otherwise, if cnt < STABLE-1: cnt increments.
  - A sample is "stable" when sync2 == cand and cnt == STABLE-1.
- Gray→binary conversion: b[BITS-1] = g[BITS-1]; b[i] = b[i+1] ^ g[i].
- State ACQUIRE, on a stable sample:
  - acc_bin ← conv(cand) and bin_out ← conv(cand).
  - No step_valid, no err, pos unchanged.
  - Go to TRACK.
- State TRACK, on a stable sample with new = conv(cand) ≠ acc_bin:
  - Compute d = (new − acc_bin) mod 2^BITS.
  - d == 1: step_valid = 1, step_dir = 1, pos ← pos + 1.
  - d == 2^BITS − 1: step_valid = 1, step_dir = 0, pos ← pos − 1.
  - Any other d: err = 1, err_sticky ← 1, pos unchanged.
  - In all three cases acc_bin ← new and bin_out ← new, so the decoder resynchronises to the new baseline.
- A stable sample with new == acc_bin causes no action. A held input therefore produces no repeated pulses.
- Counter wrap:
  - bin wrap 2^BITS−1 → 0 is a legal up-step; 0 → 2^BITS−1 is a legal down-step.
  - pos wraps silently in both directions.
- clr_err and a new err in the same cycle: err_sticky = 1 (set wins).
- TRACK has no exit other than rst.
- rst asserted mid-operation: every register returns to its reset value on that edge. The next baseline is acquired without any step or err pulse.

## Timing
- Let the new gray_in value be stable before edge 0.
  - Captured by sync1 at edge 0 and by sync2 at edge 1.
  - Loaded into cand at edge 2.
  - bin_out, pos, step_valid, step_dir and err all update together at edge 2+STABLE, i.e. edge 6 at the default.
- Glitch rejection: any change shorter than STABLE+1 cycles at sync2 is never accepted.
- The fastest trackable input rate is one change per STABLE+1 cycles.
- step_valid and err are each high for exactly one cycle and never high together.
- The locked rising edge coincides with the ACQUIRE baseline load.

## Test plan
1. Reset baseline: hold rst for 3 cycles with gray_in = 0x00, then release.
   - During reset: all outputs are 0.
   - At edge STABLE+1 after release: locked = 1, with no step_valid and no err.
2. Up count: drive gray 0x00, 0x01, 0x03, 0x02, each held 10 cycles.
   - Three step_valid pulses, each with step_dir = 1.
   - Final state: pos = 3, bin_out = 0x03, err = 0 throughout.
3. Down wrap: from locked at 0x00, drive 0x80.
   - One step_valid pulse with step_dir = 0.
   - bin_out = 0xFF, pos = 0xFFFF.
4. Glitch: from 0x00, drive 0x01 for 3 cycles, then return to 0x00.
   - No step_valid, no err; bin_out stays 0, pos stays 0.
5. Illegal jump: from 0x00, drive 0x03.
   - At edge 6: err pulses, err_sticky = 1, bin_out = 0x02, pos = 0.
   - Then drive 0x02: step up, pos = 1.
   - clr_err pulse: err_sticky = 0.
   - clr_err coinciding with a fresh err: err_sticky stays 1.
6. Reset mid-run: at pos = 5 with gray_in = 0x07, assert rst for 1 cycle.
   - On that edge: all outputs are 0.
   - The decoder re-locks with bin_out = 0x05 and pos = 0, with no step_valid and no err.
